// File: rtl/parking_pkg.sv
// Shared types and constants for the parking gate controller slice.
// Latency: none (declarations only).
// Backpressure: none (declarations only).
package parking_pkg;

    localparam int SPOT_W          = 3;
    localparam int NUM_SPOTS       = 8;
    localparam int FREE_W          = 4;
    localparam int GATE_CYCLES_DEF = 4;
    // exit_err is a single-cycle pulse
    localparam int ACK_CYCLES      = 1;

    typedef enum logic [2:0] {
        S_IDLE     = 3'd0,
        S_ALLOC    = 3'd1,
        S_VERIFY   = 3'd2,
        S_OPEN_IN  = 3'd3,
        S_OPEN_OUT = 3'd4,
        S_REJECT   = 3'd5,
        S_WAIT_REL = 3'd6
    } state_t;

    // Number of zero bits in the occupancy map
    function automatic logic [FREE_W-1:0] free_of(input logic [NUM_SPOTS-1:0] occ);
        logic [FREE_W-1:0] n;
        n = FREE_W'(NUM_SPOTS);
        for (int i = 0; i < NUM_SPOTS; i++) begin
            n = n - FREE_W'(occ[i]);
        end
        return n;
    endfunction

endpackage

// File: rtl/token_production.sv
// Token mapping: result = val ^ pattern; used both to encode spot->token and decode token->spot.
// Latency: combinational, zero cycles.
// Backpressure: none; pure function of its inputs.
module token_production
    import parking_pkg::*;
(
    input  logic [SPOT_W-1:0] val,
    input  logic [SPOT_W-1:0] pattern,
    output logic [SPOT_W-1:0] result
);

    assign result = val ^ pattern;

endmodule

// File: rtl/parking_gate_controller.sv
// Parking lot sequencer: allocates lowest free spot on entry, validates exit tokens, drives both gates.
// Latency: ack/err pulse 2 cycles after the request is sampled in IDLE; gate then open GATE_CYCLES cycles.
// Backpressure: 4-phase level handshake; one request served at a time, next only after the served one drops.
module parking_gate_controller
    import parking_pkg::*;
#(
    parameter int                GATE_CYCLES     = GATE_CYCLES_DEF,
    parameter logic [SPOT_W-1:0] DEFAULT_PATTERN = 3'd0
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 car_in_req,
    input  logic                 car_out_req,
    input  logic [SPOT_W-1:0]    token_in,
    input  logic                 cfg_load,
    input  logic [SPOT_W-1:0]    cfg_pattern,
    output logic                 entry_ack,
    output logic [SPOT_W-1:0]    token_out,
    output logic                 exit_ack,
    output logic                 exit_err,
    output logic                 gate_in_open,
    output logic                 gate_out_open,
    output logic [NUM_SPOTS-1:0] occupancy,
    output logic [FREE_W-1:0]    free_count,
    output logic                 full,
    output logic                 cfg_err
);

    localparam int CNT_W = $clog2(GATE_CYCLES + ACK_CYCLES + 1);

    state_t               state, state_nxt;
    logic [CNT_W-1:0]     cnt, cnt_nxt;
    logic [SPOT_W-1:0]    spot_r, spot_nxt;
    logic                 served_out, served_out_nxt;
    logic [SPOT_W-1:0]    pattern;
    logic [SPOT_W-1:0]    low_free;
    logic [SPOT_W-1:0]    enc_tok;
    logic [SPOT_W-1:0]    dec_spot;
    logic [NUM_SPOTS-1:0] occ_nxt;
    logic                 open_lead;
    logic                 cfg_ok;

    token_production u_encode (
        .val     (spot_r),
        .pattern (pattern),
        .result  (enc_tok)
    );

    token_production u_decode (
        .val     (token_in),
        .pattern (pattern),
        .result  (dec_spot)
    );

    // Lowest-index free spot; scanning downward lets the smallest index win
    always_comb begin
        low_free = '0;
        for (int i = NUM_SPOTS - 1; i >= 0; i--) begin
            if (!occupancy[i]) begin
                low_free = SPOT_W'(i);
            end
        end
    end

    // State register plus the spot/counter context of the transaction in flight
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state      <= S_IDLE;
            cnt        <= '0;
            spot_r     <= '0;
            served_out <= 1'b0;
        end else begin
            state      <= state_nxt;
            cnt        <= cnt_nxt;
            spot_r     <= spot_nxt;
            served_out <= served_out_nxt;
        end
    end

    // Next-state logic; open/reject states spend one lead cycle before their pulse
    always_comb begin
        state_nxt      = state;
        cnt_nxt        = cnt;
        spot_nxt       = spot_r;
        served_out_nxt = served_out;
        case (state)
            S_IDLE: begin
                if (car_out_req) begin
                    state_nxt      = S_VERIFY;
                    served_out_nxt = 1'b1;
                end else if (car_in_req && !full) begin
                    state_nxt      = S_ALLOC;
                    served_out_nxt = 1'b0;
                end
            end
            S_ALLOC: begin
                spot_nxt  = low_free;
                cnt_nxt   = CNT_W'(GATE_CYCLES);
                state_nxt = S_OPEN_IN;
            end
            S_VERIFY: begin
                spot_nxt = dec_spot;
                if (occupancy[dec_spot]) begin
                    cnt_nxt   = CNT_W'(GATE_CYCLES);
                    state_nxt = S_OPEN_OUT;
                end else begin
                    cnt_nxt   = CNT_W'(ACK_CYCLES);
                    state_nxt = S_REJECT;
                end
            end
            S_OPEN_IN, S_OPEN_OUT, S_REJECT: begin
                if (cnt == '0) begin
                    state_nxt = S_WAIT_REL;
                end else begin
                    cnt_nxt = cnt - CNT_W'(1);
                end
            end
            S_WAIT_REL: begin
                if (!(served_out ? car_out_req : car_in_req)) begin
                    state_nxt = S_IDLE;
                end
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    // Moore outputs decoded from state and the gate counter
    always_comb begin
        entry_ack     = 1'b0;
        exit_ack      = 1'b0;
        exit_err      = 1'b0;
        gate_in_open  = 1'b0;
        gate_out_open = 1'b0;
        case (state)
            S_OPEN_IN: begin
                entry_ack    = (cnt == CNT_W'(GATE_CYCLES - 1));
                gate_in_open = (cnt != CNT_W'(GATE_CYCLES));
            end
            S_OPEN_OUT: begin
                exit_ack      = (cnt == CNT_W'(GATE_CYCLES - 1));
                gate_out_open = (cnt != CNT_W'(GATE_CYCLES));
            end
            S_REJECT: begin
                exit_err = (cnt != CNT_W'(ACK_CYCLES));
            end
            default: ;
        endcase
    end

    // The lead cycle of an open state is where the occupancy map changes
    assign open_lead = (cnt == CNT_W'(GATE_CYCLES));
    // Pattern may only move when no token can be outstanding and nothing is pending
    assign cfg_ok    = (state == S_IDLE) && (occupancy == '0) && !car_in_req && !car_out_req;
    assign full      = (free_count == '0);

    // Next occupancy map, so free_count can be registered alongside it
    always_comb begin
        occ_nxt = occupancy;
        if (state == S_OPEN_IN && open_lead) begin
            occ_nxt[spot_r] = 1'b1;
        end else if (state == S_OPEN_OUT && open_lead) begin
            occ_nxt[spot_r] = 1'b0;
        end
    end

    // Occupancy, free count, issued token and pattern register
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            occupancy  <= '0;
            free_count <= FREE_W'(NUM_SPOTS);
            token_out  <= '0;
            pattern    <= DEFAULT_PATTERN;
            cfg_err    <= 1'b0;
        end else begin
            occupancy  <= occ_nxt;
            free_count <= free_of(occ_nxt);
            cfg_err    <= 1'b0;
            if (state == S_OPEN_IN && open_lead) begin
                token_out <= enc_tok;
            end
            if (cfg_load) begin
                if (cfg_ok) begin
                    pattern <= cfg_pattern;
                end else begin
                    cfg_err <= 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_parking_gate_controller.sv
// Directed-vector bench for parking_gate_controller with hand-computed expectations.
// Latency: checks ack exactly on the third falling edge after a request is raised.
// Backpressure: requests held until the gate sequence completes, then dropped.
module tb_parking_gate_controller;

    logic       clk;
    logic       rst_n;
    logic       car_in_req;
    logic       car_out_req;
    logic [2:0] token_in;
    logic       cfg_load;
    logic [2:0] cfg_pattern;
    logic       entry_ack;
    logic [2:0] token_out;
    logic       exit_ack;
    logic       exit_err;
    logic       gate_in_open;
    logic       gate_out_open;
    logic [7:0] occupancy;
    logic [3:0] free_count;
    logic       full;
    logic       cfg_err;

    int n_vec  = 0;
    int n_miss = 0;

    parking_gate_controller dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .car_in_req    (car_in_req),
        .car_out_req   (car_out_req),
        .token_in      (token_in),
        .cfg_load      (cfg_load),
        .cfg_pattern   (cfg_pattern),
        .entry_ack     (entry_ack),
        .token_out     (token_out),
        .exit_ack      (exit_ack),
        .exit_err      (exit_err),
        .gate_in_open  (gate_in_open),
        .gate_out_open (gate_out_open),
        .occupancy     (occupancy),
        .free_count    (free_count),
        .full          (full),
        .cfg_err       (cfg_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_miss++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Full entry transaction: request, exact-latency ack, gate length, release
    task automatic entry(input logic [2:0] tok, input logic [7:0] occ, input logic [3:0] fc);
        int g;
        int a;
        car_in_req = 1'b1;
        repeat (2) begin
            @(negedge clk);
            chk("entry_early", entry_ack, 1'b0);
        end
        @(negedge clk);
        chk("entry_ack", entry_ack, 1'b1);
        chk("token_out", token_out, tok);
        chk("entry_occ", occupancy, occ);
        chk("entry_free", free_count, fc);
        chk("entry_full", full, fc == 4'd0);
        g = 0;
        a = 0;
        for (int i = 0; i < 8; i++) begin
            if (gate_in_open) g++;
            if (gate_out_open) g += 100;
            if (entry_ack) a++;
            @(negedge clk);
        end
        chk("gate_in_len", g, 4);
        chk("entry_ack_once", a, 1);
        car_in_req = 1'b0;
        @(negedge clk);
    endtask

    // Accepted exit; also proves no entry is granted while the exit is served
    task automatic exit_ok(input logic [2:0] tin, input logic [7:0] occ, input logic [3:0] fc);
        int g;
        int bad;
        car_out_req = 1'b1;
        token_in    = tin;
        repeat (2) begin
            @(negedge clk);
            chk("exit_early", {exit_ack, exit_err}, 2'b00);
        end
        @(negedge clk);
        chk("exit_ack", {exit_ack, exit_err}, 2'b10);
        chk("exit_occ", occupancy, occ);
        chk("exit_free", free_count, fc);
        g   = 0;
        bad = 0;
        for (int i = 0; i < 8; i++) begin
            if (gate_out_open) g++;
            if (gate_in_open || entry_ack) bad++;
            @(negedge clk);
        end
        chk("gate_out_len", g, 4);
        chk("exit_no_entry", bad, 0);
        car_out_req = 1'b0;
        @(negedge clk);
    endtask

    // Rejected exit: single err pulse, gates closed, map untouched
    task automatic exit_rej(input logic [2:0] tin, input logic [7:0] occ);
        int e;
        int g;
        car_out_req = 1'b1;
        token_in    = tin;
        repeat (2) begin
            @(negedge clk);
            chk("rej_early", exit_err, 1'b0);
        end
        @(negedge clk);
        chk("exit_err", {exit_ack, exit_err}, 2'b01);
        chk("rej_occ", occupancy, occ);
        e = 0;
        g = 0;
        for (int i = 0; i < 8; i++) begin
            if (exit_err) e++;
            if (gate_in_open || gate_out_open || exit_ack || entry_ack) g++;
            @(negedge clk);
        end
        chk("rej_err_once", e, 1);
        chk("rej_gates", g, 0);
        car_out_req = 1'b0;
        @(negedge clk);
    endtask

    // Wait (bounded) for an entry ack on a request that is already held
    task automatic poll_entry(input int exp_n, input logic [2:0] tok, input logic [7:0] occ,
                              input logic [3:0] fc);
        int n;
        n = 0;
        for (int i = 1; i <= 10 && n == 0; i++) begin
            @(negedge clk);
            if (entry_ack) n = i;
        end
        chk("held_entry_lat", n, exp_n);
        chk("held_token", token_out, tok);
        chk("held_occ", occupancy, occ);
        chk("held_free", free_count, fc);
        repeat (8) @(negedge clk);
        car_in_req = 1'b0;
        @(negedge clk);
    endtask

    initial begin
        int a;
        rst_n       = 1'b0;
        car_in_req  = 1'b0;
        car_out_req = 1'b0;
        token_in    = 3'd0;
        cfg_load    = 1'b0;
        cfg_pattern = 3'd0;
        repeat (2) @(negedge clk);

        // 1: reset state, pattern load, first entry
        chk("rst_occ", occupancy, 8'h00);
        chk("rst_free", free_count, 4'd8);
        chk("rst_outs", {entry_ack, exit_ack, exit_err, gate_in_open, gate_out_open, full, cfg_err},
            7'b0);
        chk("rst_token", token_out, 3'd0);
        rst_n       = 1'b1;
        cfg_load    = 1'b1;
        cfg_pattern = 3'd2;
        @(negedge clk);
        cfg_load = 1'b0;
        chk("cfg_accept", cfg_err, 1'b0);
        entry(3'b010, 8'h01, 4'd7);

        // 2: second entry then exit of spot 1
        entry(3'b011, 8'h03, 4'd6);
        exit_ok(3'b011, 8'h01, 4'd7);

        // 3: exit with a token decoding to a free spot
        exit_rej(3'b111, 8'h01);

        // 4: fill the lot, hold a 9th entry, free spot 3, entry takes spot 3
        entry(3'b011, 8'h03, 4'd6);
        entry(3'b000, 8'h07, 4'd5);
        entry(3'b001, 8'h0F, 4'd4);
        entry(3'b110, 8'h1F, 4'd3);
        entry(3'b111, 8'h3F, 4'd2);
        entry(3'b100, 8'h7F, 4'd1);
        entry(3'b101, 8'hFF, 4'd0);
        car_in_req = 1'b1;
        a = 0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            if (entry_ack) a++;
        end
        chk("full_no_ack", a, 0);
        chk("full_flag", full, 1'b1);
        exit_ok(3'b001, 8'hF7, 4'd1);
        poll_entry(3, 3'b001, 8'hFF, 4'd0);

        // 5: simultaneous requests, exit first
        exit_ok(3'b010, 8'hFE, 4'd1);
        car_in_req = 1'b1;
        exit_ok(3'b101, 8'h7E, 4'd2);
        poll_entry(3, 3'b010, 8'h7F, 4'd1);

        // 6: refused cfg_load, pattern kept, reset mid-entry
        cfg_load    = 1'b1;
        cfg_pattern = 3'd5;
        @(negedge clk);
        cfg_load = 1'b0;
        chk("cfg_err_pulse", cfg_err, 1'b1);
        @(negedge clk);
        chk("cfg_err_clear", cfg_err, 1'b0);
        exit_ok(3'b010, 8'h7E, 4'd2);
        entry(3'b010, 8'h7F, 4'd1);
        car_in_req = 1'b1;
        repeat (3) @(negedge clk);
        chk("pre_rst_ack", entry_ack, 1'b1);
        chk("pre_rst_gate", gate_in_open, 1'b1);
        chk("pre_rst_token", token_out, 3'b101);
        chk("pre_rst_occ", occupancy, 8'hFF);
        rst_n = 1'b0;
        @(negedge clk);
        chk("mid_rst_gate", gate_in_open, 1'b0);
        chk("mid_rst_occ", occupancy, 8'h00);
        chk("mid_rst_free", free_count, 4'd8);
        chk("mid_rst_outs", {entry_ack, full, token_out}, 5'b0);
        car_in_req = 1'b0;
        rst_n      = 1'b1;
        @(negedge clk);
        entry(3'b000, 8'h01, 4'd7);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
